// File: rtl/grant_dispatch.sv
// Grant dispatch: encodes the arbiter's one-hot grant, captures the granted payload
// and queues (index, payload) in a circular FIFO drained over a valid/ready port.
module grant_dispatch #(
    parameter  int N     = 32,
    parameter  int W     = 32,
    parameter  int DEPTH = 4,
    localparam int IDW   = $clog2(N),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     gnt,
    input  logic [N*W-1:0]   req_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDW-1:0]   out_id,
    output logic [W-1:0]     out_data,
    output logic [LW-1:0]    level,
    output logic             afull,
    output logic             ovf_err,
    output logic             oh_err,
    output logic [7:0]       drop_cnt,
    input  logic             err_clr
);

    localparam int              PW        = $clog2(DEPTH);
    localparam logic [LW-1:0]   LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0]   LVL_AFULL = LW'(DEPTH - 1);
    localparam logic [PW-1:0]   PTR_ONE   = PW'(1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [IDW-1:0] id_mem   [DEPTH];
    logic [W-1:0]   data_mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // Stage p0: combinational grant decode, written into storage at the end of the cycle
    logic           multi_p0;
    logic           vld_p0;
    logic           bad_p0;
    logic [IDW-1:0] id_p0;
    logic [W-1:0]   data_p0;

    // AND-OR encoder and payload select: valid only for one-hot gnt, no priority chain
    always_comb begin
        id_p0   = '0;
        data_p0 = '0;
        for (int i = 0; i < N; i++) begin
            id_p0   = id_p0   | (IDW'(i) & {IDW{gnt[i]}});
            data_p0 = data_p0 | (req_data[i*W +: W] & {W{gnt[i]}});
        end
    end

    assign multi_p0 = |(gnt & (gnt - N'(1)));
    assign vld_p0   = (|gnt) && !multi_p0;
    assign bad_p0   = multi_p0;

    logic          pop;
    logic          push;
    logic          ovf_ev;
    logic          drop_ev;
    logic [LW-1:0] level_nxt;

    assign pop     = out_valid && out_ready;
    assign push    = vld_p0 && ((level != LVL_FULL) || pop);
    assign ovf_ev  = vld_p0 && (level == LVL_FULL) && !pop;
    assign drop_ev = ovf_ev || bad_p0;

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    // When full with a simultaneous pop, wr_ptr == rd_ptr: the head is read out this
    // cycle and the new entry lands in its slot, becoming the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                id_mem[wr_ptr]   <= id_p0;
                data_mem[wr_ptr] <= data_p0;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level     <= '0;
            out_valid <= 1'b0;
            afull     <= 1'b0;
        end else begin
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            afull     <= (level_nxt >= LVL_AFULL);
        end
    end

    // Clear wins over a same-cycle drop; the concurrent event is lost by design
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err  <= 1'b0;
            oh_err   <= 1'b0;
            drop_cnt <= '0;
        end else if (err_clr) begin
            ovf_err  <= 1'b0;
            oh_err   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (ovf_ev) ovf_err <= 1'b1;
            if (bad_p0) oh_err  <= 1'b1;
            if (drop_ev) drop_cnt <= sat_inc8(drop_cnt);
        end
    end

    assign out_id   = id_mem[rd_ptr];
    assign out_data = data_mem[rd_ptr];

endmodule

// File: tb/tb_grant_dispatch.sv
// Scoreboard bench for grant_dispatch: directed grant sequences push expected entries,
// a negedge monitor pops and compares on every accepted head.
module tb_grant_dispatch;

    localparam int N     = 32;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int IDW   = 5;
    localparam int LW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     gnt;
    logic [N*W-1:0]   req_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDW-1:0]   out_id;
    logic [W-1:0]     out_data;
    logic [LW-1:0]    level;
    logic             afull;
    logic             ovf_err;
    logic             oh_err;
    logic [7:0]       drop_cnt;
    logic             err_clr;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    grant_dispatch #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gnt       (gnt),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_data  (out_data),
        .level     (level),
        .afull     (afull),
        .ovf_err   (ovf_err),
        .oh_err    (oh_err),
        .drop_cnt  (drop_cnt),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pat(input int i);
        return {8'hD0, 8'(i), 8'h5A, ~8'(i)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a grant to requester i and record the entry the FIFO should eventually emit
    task automatic grant_exp(input int i);
        exp_t e;
        gnt    = '0;
        gnt[i] = 1'b1;
        e.id   = IDW'(i);
        e.data = req_data[i*W +: W];
        sb_q.push_back(e);
    endtask

    task automatic grant_drop(input int i);
        gnt    = '0;
        gnt[i] = 1'b1;
    endtask

    // Monitor: a handshake seen at the negedge completes on the following posedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_pop: got id %0d data %0h, expected no entry", out_id, out_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("pop_id", 32'(out_id), 32'(e.id));
                    chk("pop_data", out_data, e.data);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        gnt       = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = pat(i);
        req_data[0 +: W] = 32'hA5A5_0000;

        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_id", 32'(out_id), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_afull", 32'(afull), 0);
        chk("rst_ovf_err", 32'(ovf_err), 0);
        chk("rst_oh_err", 32'(oh_err), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        rst_n = 1'b1;

        // Single grant, immediate drain
        out_ready = 1'b1;
        grant_exp(0);
        tick();
        gnt = '0;
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_id", 32'(out_id), 0);
        chk("t1_data", out_data, 32'hA5A5_0000);
        chk("t1_level", 32'(level), 1);
        tick();
        chk("t1_valid_after", 32'(out_valid), 0);
        chk("t1_level_after", 32'(level), 0);

        // Fill with consumer stalled, fifth grant overflows
        out_ready = 1'b0;
        grant_exp(3);  tick();
        chk("fill_lvl1", 32'(level), 1);
        chk("fill_afull1", 32'(afull), 0);
        grant_exp(7);  tick();
        chk("fill_lvl2", 32'(level), 2);
        chk("fill_afull2", 32'(afull), 0);
        grant_exp(31); tick();
        chk("fill_lvl3", 32'(level), 3);
        chk("fill_afull3", 32'(afull), 1);
        grant_exp(12); tick();
        chk("fill_lvl4", 32'(level), 4);
        chk("fill_afull4", 32'(afull), 1);
        chk("fill_ovf_before", 32'(ovf_err), 0);
        grant_drop(5); tick();
        chk("ovf_level", 32'(level), 4);
        chk("ovf_err", 32'(ovf_err), 1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 1);

        // Full with simultaneous pop and push
        out_ready = 1'b1;
        grant_exp(9);  tick();
        gnt = '0;
        chk("fullpp_level", 32'(level), 4);
        chk("fullpp_drop_cnt", 32'(drop_cnt), 1);
        chk("fullpp_oh_err", 32'(oh_err), 0);
        for (int k = 3; k >= 0; k--) begin
            tick();
            chk("drain_level", 32'(level), 32'(k));
        end
        chk("drain_valid", 32'(out_valid), 0);
        err_clr = 1'b1; tick();
        err_clr = 1'b0;
        chk("clr_ovf_err", 32'(ovf_err), 0);
        chk("clr_drop_cnt", 32'(drop_cnt), 0);

        // Malformed grant, then clear racing a second malformed grant
        gnt = 32'h0000_0006; tick();
        chk("mal_level", 32'(level), 0);
        chk("mal_valid", 32'(out_valid), 0);
        chk("mal_oh_err", 32'(oh_err), 1);
        chk("mal_ovf_err", 32'(ovf_err), 0);
        chk("mal_drop_cnt", 32'(drop_cnt), 1);
        err_clr = 1'b1; tick();
        gnt     = '0;
        err_clr = 1'b0;
        chk("clr_race_oh_err", 32'(oh_err), 0);
        chk("clr_race_drop_cnt", 32'(drop_cnt), 0);

        // Saturation of the drop counter
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            grant_exp(i); tick();
        end
        chk("sat_fill_level", 32'(level), 4);
        grant_drop(8);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 253) chk("sat_drop_254", 32'(drop_cnt), 254);
        end
        gnt = '0;
        chk("sat_drop_300", 32'(drop_cnt), 255);
        chk("sat_ovf_err", 32'(ovf_err), 1);
        chk("sat_level", 32'(level), 4);
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        chk("pre_rst_level", 32'(level), 3);

        // Asynchronous reset with entries queued
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_id", 32'(out_id), 0);
        chk("arst_data", out_data, 0);
        chk("arst_afull", 32'(afull), 0);
        chk("arst_ovf_err", 32'(ovf_err), 0);
        chk("arst_drop_cnt", 32'(drop_cnt), 0);
        sb_q.delete();
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        grant_exp(20); tick();
        gnt = '0;
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_id", 32'(out_id), 20);
        chk("post_rst_level", 32'(level), 1);
        tick();
        chk("post_rst_level_end", 32'(level), 0);
        chk("sb_leftover", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/grant_dispatch.md
# grant_dispatch

Downstream stage of the round-robin arbiter: consumes its registered one-hot `gnt` vector each cycle, encodes it to a requester index, captures the granted requester's payload, and queues (index, payload) in a DEPTH-entry FIFO drained through a valid/ready port. The arbiter cannot stall, so this block absorbs bursts, reports fill level, and flags dropped or malformed grants.

## Interface

- `N`, 32, number of requesters; must match the arbiter.
- `W`, 32, payload width per requester.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `IDW`, `$clog2(N)`, index width; derived, not overridden.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `gnt`  in  N  one-hot grant from the arbiter (all-zero = no grant).
- `req_data`  in  N*W  payloads; slice i = `req_data[i*W +: W]`.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_id`  out  IDW  requester index of head entry.
- `out_data`  out  W  payload of head entry.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `afull`  out  1  `level >= DEPTH-1`.
- `ovf_err`  out  1  sticky: a valid grant was dropped because FIFO was full.
- `oh_err`  out  1  sticky: `gnt` had more than one bit set.
- `drop_cnt`  out  8  saturating count of dropped grants (overflow or non-one-hot).
- `err_clr`  in  1  synchronous clear of `ovf_err`, `oh_err`, `drop_cnt`.

## Operation

- Grant classification each cycle: `gnt == 0` → idle; exactly one bit set → valid grant; ≥2 bits → malformed.
- Valid grant: index i encoded (OR-tree encoder, no priority chain), slice i of `req_data` sampled in the same cycle; push request raised.
- Pop = `out_valid && out_ready`. Push accepted if `level < DEPTH` or pop in same cycle.
- Full + valid grant + pop: push and pop both happen; `level` unchanged; entry written to the freed slot order-correctly (FIFO order preserved).
- Full + valid grant + no pop: entry dropped; `ovf_err` ← 1; `drop_cnt` += 1.
- Malformed grant: nothing pushed; `oh_err` ← 1; `drop_cnt` += 1. Overflow condition not additionally evaluated.
- `drop_cnt` saturates at 255; never wraps.
- `err_clr` has priority over a same-cycle set: flags and counter go to 0 that edge, the concurrent event is not recorded.
- Storage: circular buffer, read/write pointers `$clog2(DEPTH)` bits wrapping modulo DEPTH; `level` tracked as explicit counter (+1 push only, −1 pop only, unchanged on both/neither).
- `out_id`/`out_data` driven from storage at the read pointer; stable while `out_valid && !out_ready`.
- Empty: `out_valid` = 0; `out_id`/`out_data` are don't-care but must not be X after reset (storage reset to 0).

## Timing

- Reset (async assert, sync-to-clk deassert assumed upstream): `out_valid`=0, `out_id`=0, `out_data`=0, `level`=0, `afull`=0, `ovf_err`=0, `oh_err`=0, `drop_cnt`=0, pointers 0.
- Latency: grant present in cycle t → entry written at end of t → `out_valid`=1, `level` incremented in cycle t+1 (when previously empty).
- Throughput: one push and one pop per cycle sustained; with `out_ready` held high, back-to-back grants stream with 1-cycle latency and never accumulate.
- `afull`, `level`, error flags are registered; reflect state after the most recent edge.
- Reset mid-operation: all queued entries discarded immediately; first grant after deassert handled normally.
- No combinational path from `gnt`/`req_data` to any output; `out_ready` affects only next-state.

## Test plan

- Reset then `gnt`=0x0000_0001, `req_data[0 +: 32]`=0xA5A5_0000, `out_ready`=1 → next cycle `out_valid`=1, `out_id`=0, `out_data`=0xA5A5_0000; following cycle `out_valid`=0.
- `out_ready`=0, grants to 3,7,31,12,5 on consecutive cycles (DEPTH=4) → `level` 1,2,3,4; `afull` from level 3; grant 5 dropped, `ovf_err`=1, `drop_cnt`=1; then drain yields ids 3,7,31,12 in order.
- Full FIFO, `out_ready`=1, grant to 9 same cycle → `level` stays 4, no error; id 9 appears after the existing three entries.
- `gnt`=0x0000_0006 → nothing queued, `oh_err`=1, `drop_cnt`=1; `err_clr` pulse → flags and counter 0 next cycle.
- 300 overflow drops with `out_ready`=0 → `drop_cnt`=255, no wrap.
- Assert `rst_n`=0 with 3 entries queued → all outputs to reset values asynchronously; after release, `gnt` bit 20 → `out_id`=20 after one cycle.
